mac_lane_acc: RTL and testbench



---
 rtl/mac_lane_acc_if.sv | 28 ++
 rtl/mac_lane_acc.sv | 155 +++++++++++++++
 tb/tb_mac_lane_acc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_lane_acc_if.sv
// Beat/result bundle for mac_lane_acc; fetch logic drives the master side, the MAC engine is the slave.
interface mac_lane_acc_if #(
   parameter int unsigned LANES = 4,
   parameter int unsigned IN_W  = 8,
   parameter int unsigned W_W   = 8,
   parameter int unsigned ACC_W = 32
);
   logic                    in_valid;
   logic                    in_first;
   logic                    in_last;
   logic                    signed_act;
   logic [LANES-1:0]        lane_mask;
   logic [LANES*IN_W-1:0]   act;
   logic [LANES*W_W-1:0]    weight;
   logic [ACC_W-1:0]        result;
   logic                    out_valid;
   logic                    ovf;

   modport master (
      output in_valid, in_first, in_last, signed_act, lane_mask, act, weight,
      input  result, out_valid, ovf
   );

   modport slave (
      input  in_valid, in_first, in_last, signed_act, lane_mask, act, weight,
      output result, out_valid, ovf
   );
endinterface

// File: rtl/mac_lane_acc.sv
// Multi-lane signed MAC: per-beat lane products, adder-tree reduction, framed accumulation.
// Define MAC_LANE_ACC_SAT_EN for a saturating accumulator with a sticky per-sequence ovf flag.
module mac_lane_acc #(
   parameter int unsigned LANES = 4,
   parameter int unsigned IN_W  = 8,
   parameter int unsigned W_W   = 8,
   parameter int unsigned ACC_W = 32
) (
   input logic           clk,
   input logic           rstn,
   mac_lane_acc_if.slave bus
);
   localparam int unsigned PROD_W = IN_W + W_W + 1;
   localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);

   // Activation widened by one bit so unsigned values stay positive in the signed product
   function automatic logic signed [PROD_W-1:0] lane_prod(input logic [IN_W-1:0] a,
                                                          input logic [W_W-1:0]  w,
                                                          input logic            sgn);
      logic signed [PROD_W-1:0] ax;
      logic signed [PROD_W-1:0] wx;
      ax = PROD_W'($signed({sgn & a[IN_W-1], a}));
      wx = PROD_W'($signed(w));
      return ax * wx;
   endfunction

   logic                     s0_valid, s0_first, s0_last, s0_signed;
   logic [LANES-1:0]         s0_mask;
   logic [LANES*IN_W-1:0]    s0_act;
   logic [LANES*W_W-1:0]     s0_weight;
   logic signed [PROD_W-1:0] prod_c [LANES];
   logic                     s1_valid, s1_first, s1_last;
   logic signed [PROD_W-1:0] s1_prod [LANES];
   logic signed [SUM_W-1:0]  tree_c [2*LANES];
   logic                     s2_valid, s2_first, s2_last;
   logic signed [SUM_W-1:0]  s2_sum;
   logic signed [ACC_W-1:0]  acc, acc_nxt, base, sum_ext, res_q;
   logic                     out_valid_q;

   // S0: input capture
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s0_valid  <= 1'b0;
         s0_first  <= 1'b0;
         s0_last   <= 1'b0;
         s0_signed <= 1'b0;
         s0_mask   <= '0;
         s0_act    <= '0;
         s0_weight <= '0;
      end else begin
         s0_valid  <= bus.in_valid;
         s0_first  <= bus.in_first;
         s0_last   <= bus.in_last;
         s0_signed <= bus.signed_act;
         s0_mask   <= bus.lane_mask;
         s0_act    <= bus.act;
         s0_weight <= bus.weight;
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod_c[i] = '0;
         if (s0_mask[i])
            prod_c[i] = lane_prod(s0_act[i*IN_W +: IN_W], s0_weight[i*W_W +: W_W], s0_signed);
      end
   end

   // S1: lane products
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
      end else begin
         s1_valid <= s0_valid;
         s1_first <= s0_first;
         s1_last  <= s0_last;
         for (int i = 0; i < LANES; i++) s1_prod[i] <= prod_c[i];
      end
   end

   // Heap-ordered binary tree: leaves at LANES..2*LANES-1, root at index 1
   always_comb begin
      tree_c[0] = '0;
      for (int i = 0; i < LANES; i++) tree_c[LANES+i] = SUM_W'(s1_prod[i]);
      for (int n = LANES - 1; n >= 1; n--) tree_c[n] = tree_c[2*n] + tree_c[2*n+1];
   end

   // S2: beat sum
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_sum   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;
         s2_sum   <= tree_c[1];
      end
   end

   assign sum_ext = ACC_W'(s2_sum);
   assign base    = s2_first ? '0 : acc;

`ifdef MAC_LANE_ACC_SAT_EN
   localparam int unsigned ACC_X = ACC_W + 1;
   logic signed [ACC_W:0] wide;
   logic                  sat;
   logic                  ovf_q;

   assign wide = ACC_X'(base) + ACC_X'(sum_ext);
   assign sat  = wide[ACC_W] ^ wide[ACC_W-1];

   always_comb begin
      acc_nxt = wide[ACC_W-1:0];
      if (sat)
         acc_nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

   // Sticky within a sequence; a first beat starts it afresh
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ovf_q <= 1'b0;
      else if (s2_valid)
         ovf_q <= (s2_first ? 1'b0 : ovf_q) | sat;
   end

   assign bus.ovf = ovf_q;
`else
   assign acc_nxt = base + sum_ext;
   assign bus.ovf = 1'b0;
`endif

   // S3: accumulator and result
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc         <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= s2_valid & s2_last;
         if (s2_valid)
            acc <= acc_nxt;
         if (s2_valid & s2_last)
            res_q <= acc_nxt;
      end
   end

   assign bus.result    = res_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mac_lane_acc.sv
// Randomised and directed bench for mac_lane_acc: a 32-bit and a 20-bit accumulator instance share stimulus.
module tb_mac_lane_acc;
   typedef struct packed {
      int     cyc;
      longint res;
      bit     ovf;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mac_lane_acc_if #(.LANES(4), .IN_W(8), .W_W(8), .ACC_W(32)) bw ();
   mac_lane_acc_if #(.LANES(4), .IN_W(8), .W_W(8), .ACC_W(20)) bn ();

   mac_lane_acc #(.LANES(4), .IN_W(8), .W_W(8), .ACC_W(32)) dut_w (.clk(clk), .rstn(rstn), .bus(bw.slave));
   mac_lane_acc #(.LANES(4), .IN_W(8), .W_W(8), .ACC_W(20)) dut_n (.clk(clk), .rstn(rstn), .bus(bn.slave));

   longint acc_m [2];
   bit     ovf_m [2];
   exp_t   q_w [$];
   exp_t   q_n [$];
   longint last_w = 0, prev_w = 0, last_n = 0;
   bit     last_n_ovf = 1'b0;
   int     pc_w = 0, pc_n = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: dot product in plain integers, then wrap or clamp to the accumulator width
   task automatic model_beat(input bit f, input bit l, input bit sgn, input logic [3:0] mask,
                             input logic [31:0] a, input logic [31:0] w, input int exp_cyc);
      longint s, v, hi;
      bit     sat;
      int     aw;
      exp_t   e;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] a8, w8;
         a8 = a[i*8 +: 8];
         w8 = w[i*8 +: 8];
         if (mask[i])
            s += (sgn ? longint'($signed(a8)) : longint'(a8)) * longint'($signed(w8));
      end
      for (int d = 0; d < 2; d++) begin
         aw  = (d == 0) ? 32 : 20;
         v   = f ? s : acc_m[d] + s;
         hi  = (longint'(1) <<< (aw - 1)) - 1;
         sat = 1'b0;
`ifdef MAC_LANE_ACC_SAT_EN
         if (v > hi) begin
            v = hi; sat = 1'b1;
         end else if (v < -hi - 1) begin
            v = -hi - 1; sat = 1'b1;
         end
`else
         v = v & ((longint'(1) <<< aw) - 1);
         if (v > hi) v = v - (longint'(1) <<< aw);
`endif
         acc_m[d] = v;
         ovf_m[d] = (f ? 1'b0 : ovf_m[d]) | sat;
         if (l) begin
            e.cyc = exp_cyc;
            e.res = v;
            e.ovf = ovf_m[d];
            if (d == 0) q_w.push_back(e);
            else        q_n.push_back(e);
         end
      end
   endtask

   task automatic put(input bit v, input bit f, input bit l, input bit sgn,
                      input logic [3:0] mask, input logic [31:0] a, input logic [31:0] w);
      bw.in_valid = v; bw.in_first = f; bw.in_last = l; bw.signed_act = sgn;
      bw.lane_mask = mask; bw.act = a; bw.weight = w;
      bn.in_valid = v; bn.in_first = f; bn.in_last = l; bn.signed_act = sgn;
      bn.lane_mask = mask; bn.act = a; bn.weight = w;
   endtask

   // Beat is sampled at the next rising edge; its effect is visible three edges later
   task automatic drive(input bit v, input bit f, input bit l, input bit sgn,
                        input logic [3:0] mask, input logic [31:0] a, input logic [31:0] w);
      @(negedge clk);
      put(v, f, l, sgn, mask, a, w);
      if (v) model_beat(f, l, sgn, mask, a, w, cyc + 4);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         if (q_w.size() != 0 && q_w[0].cyc < cyc) begin
            chk("w_pulse_missing", cyc, q_w[0].cyc);
            void'(q_w.pop_front());
         end
         if (bw.out_valid) begin
            chk("w_pulse_expected", (q_w.size() != 0) ? 1 : 0, 1);
            if (q_w.size() != 0) begin
               e = q_w.pop_front();
               chk("w_pulse_cycle", cyc, e.cyc);
               chk("w_result", longint'($signed(bw.result)), e.res);
               chk("w_ovf", longint'(bw.ovf), longint'(e.ovf));
            end
            prev_w = last_w;
            last_w = longint'($signed(bw.result));
            pc_w++;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         if (q_n.size() != 0 && q_n[0].cyc < cyc) begin
            chk("n_pulse_missing", cyc, q_n[0].cyc);
            void'(q_n.pop_front());
         end
         if (bn.out_valid) begin
            chk("n_pulse_expected", (q_n.size() != 0) ? 1 : 0, 1);
            if (q_n.size() != 0) begin
               e = q_n.pop_front();
               chk("n_pulse_cycle", cyc, e.cyc);
               chk("n_result", longint'($signed(bn.result)), e.res);
               chk("n_ovf", longint'(bn.ovf), longint'(e.ovf));
            end
            last_n     = longint'($signed(bn.result));
            last_n_ovf = bn.ovf;
            pc_n++;
         end
      end
   end

   initial begin
      int base;
      put(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      acc_m[0] = 0; acc_m[1] = 0; ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_w_result", longint'(bw.result), 0);
      chk("rst_w_valid", longint'(bw.out_valid), 0);
      chk("rst_w_ovf", longint'(bw.ovf), 0);
      chk("rst_n_result", longint'(bn.result), 0);
      chk("rst_n_valid", longint'(bn.out_valid), 0);
      chk("rst_n_ovf", longint'(bn.ovf), 0);
      rstn = 1'b1;

      base = pc_w;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0A0A0A0A, 32'hFDFDFDFD);
      idle(6);
      chk("single_result", last_w, -120);
      chk("single_pulses", pc_w - base, 1);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h7F7F7F7F);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h7F7F7F7F);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h7F7F7F7F);
      idle(6);
      chk("seq3_result", last_w, 388620);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h7F7F7F7F);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h7F7F7F7F);
      idle(2);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h7F7F7F7F);
      idle(6);
      chk("seq3_bubble_result", last_w, 388620);

      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h80808080);
      idle(6);
      chk("signed_act_result", last_w, 512);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h80808080);
      idle(6);
      chk("unsigned_act_result", last_w, -130560);

      base = pc_w;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 32'h04030201, 32'h01010105);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h04030201, 32'h01010105);
      idle(6);
      chk("b2b_first", prev_w, 5);
      chk("b2b_second", last_w, 14);
      chk("b2b_pulses", pc_w - base, 2);

      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0A0A0A0A, 32'h7F7F7F7F);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0A0A0A0A, 32'h7F7F7F7F);
      @(negedge clk);
      rstn = 1'b0;
      put(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      acc_m[0] = 0; acc_m[1] = 0; ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
      #1;
      chk("midrst_result", longint'(bw.result), 0);
      chk("midrst_valid", longint'(bw.out_valid), 0);
      base = pc_w;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      idle(6);
      chk("midrst_no_pulse", pc_w - base, 0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0A0A0A0A, 32'hFDFDFDFD);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0A0A0A0A, 32'hFDFDFDFD);
      idle(6);
      chk("postrst_result", last_w, -240);

      for (int b = 0; b < 5; b++)
         drive(1'b1, b == 0, b == 4, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h7F7F7F7F);
      idle(6);
      chk("acc32_5beat", last_w, 647700);
`ifdef MAC_LANE_ACC_SAT_EN
      chk("acc20_sat_result", last_n, 524287);
      chk("acc20_sat_ovf", longint'(last_n_ovf), 1);
`else
      chk("acc20_wrap_result", last_n, -400876);
      chk("acc20_wrap_ovf", longint'(last_n_ovf), 0);
`endif

      for (int s = 0; s < 250; s++) begin
         int len;
         bit cont;
         len  = $urandom_range(1, 6);
         cont = ($urandom_range(0, 7) == 0);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 2))
                  drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
            drive(1'b1, (b == 0) && !cont, b == len - 1, 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, $urandom, $urandom);
         end
      end

      idle(8);
      chk("w_queue_drained", q_w.size(), 0);
      chk("n_queue_drained", q_n.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
